// File: rtl/f4_ram_reader.sv
// f4_ram_reader: walks the F4 feature-map RAM and serialises each 16-channel word
// into a 16-bit valid/ready stream tagged with its flattened index.
module f4_ram_reader #(
  parameter int DEPTH  = 25,
  parameter int ADDR_W = 7,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] f4_raddr,
  input  logic [15:0]       f4_1_rdata,
  input  logic [15:0]       f4_2_rdata,
  input  logic [15:0]       f4_3_rdata,
  input  logic [15:0]       f4_4_rdata,
  input  logic [15:0]       f4_5_rdata,
  input  logic [15:0]       f4_6_rdata,
  input  logic [15:0]       f4_7_rdata,
  input  logic [15:0]       f4_8_rdata,
  input  logic [15:0]       f4_9_rdata,
  input  logic [15:0]       f4_10_rdata,
  input  logic [15:0]       f4_11_rdata,
  input  logic [15:0]       f4_12_rdata,
  input  logic [15:0]       f4_13_rdata,
  input  logic [15:0]       f4_14_rdata,
  input  logic [15:0]       f4_15_rdata,
  input  logic [15:0]       f4_16_rdata,
  output logic [15:0]       fc_data,
  output logic [IDX_W-1:0]  fc_index,
  output logic              fc_last,
  output logic              fc_valid,
  input  logic              fc_ready
);
  typedef enum logic [2:0] {IDLE, REQ, CAPT, SEND, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        ch_q, ch_d;
  logic [255:0]      word_q, word_d;
  logic [255:0]      rdata_all;
  logic              busy_q, busy_d, done_q, done_d;
  logic              fc_valid_q, fc_valid_d, fc_last_q, fc_last_d;
  logic [15:0]       fc_data_q, fc_data_d;
  logic [IDX_W-1:0]  fc_index_q, fc_index_d;
  // channel 1 occupies the least significant slice
  assign rdata_all = {f4_16_rdata, f4_15_rdata, f4_14_rdata, f4_13_rdata,
                      f4_12_rdata, f4_11_rdata, f4_10_rdata, f4_9_rdata,
                      f4_8_rdata,  f4_7_rdata,  f4_6_rdata,  f4_5_rdata,
                      f4_4_rdata,  f4_3_rdata,  f4_2_rdata,  f4_1_rdata};
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ch_d    = ch_q;
    word_d  = word_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = REQ;
        addr_d  = '0;
        ch_d    = '0;
      end
      REQ:  state_d = CAPT;
      CAPT: begin
        word_d  = rdata_all;
        state_d = SEND;
      end
      SEND: if (fc_valid_q && fc_ready) begin
        if (ch_q != 4'd15) ch_d = ch_q + 4'd1;
        else if (addr_q != LAST_ADDR) begin
          addr_d  = addr_q + 1'b1;
          ch_d    = '0;
          state_d = REQ;
        end else state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // outputs are computed from the next state so they leave the flops aligned with it
    busy_d     = state_d != IDLE;
    done_d     = state_d == DONE;
    fc_valid_d = state_d == SEND;
    fc_data_d  = fc_valid_d ? word_d[{ch_d, 4'b0} +: 16] : '0;
    fc_index_d = fc_valid_d ? (IDX_W'(addr_d) << 4) | IDX_W'(ch_d) : '0;
    fc_last_d  = fc_valid_d && addr_d == LAST_ADDR && ch_d == 4'd15;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ch_q       <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fc_valid_q <= 1'b0;
      fc_last_q  <= 1'b0;
      fc_data_q  <= '0;
      fc_index_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ch_q       <= ch_d;
      word_q     <= word_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fc_valid_q <= fc_valid_d;
      fc_last_q  <= fc_last_d;
      fc_data_q  <= fc_data_d;
      fc_index_q <= fc_index_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign f4_raddr = addr_q;
  assign fc_valid = fc_valid_q;
  assign fc_last  = fc_last_q;
  assign fc_data  = fc_data_q;
  assign fc_index = fc_index_q;
endmodule

// File: tb/tb_f4_ram_reader.sv
// tb_f4_ram_reader: drives a DEPTH=25 and a DEPTH=1 reader from a RAM model and
// compares the captured streams against an expected beat list built from RAM contents.
module tb_f4_ram_reader;
  logic clk = 0, rst_n = 0, start0 = 0, start1 = 0, fc_ready = 0, sel = 0;
  always #5 clk = ~clk;
  logic busy0, done0, last0, valid0, busy1, done1, last1, valid1;
  logic [6:0]  raddr0, raddr1;
  logic [15:0] data0, data1;
  logic [8:0]  idx0, idx1;
  logic [15:0] mem [128][16];
  logic [15:0] rd0 [16];
  logic [15:0] rd1 [16];
  always @(posedge clk)
    for (int k = 0; k < 16; k++) begin
      rd0[k] <= mem[raddr0][k];
      rd1[k] <= mem[raddr1][k];
    end
  f4_ram_reader #(.DEPTH(25)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .f4_raddr(raddr0),
    .f4_1_rdata(rd0[0]), .f4_2_rdata(rd0[1]), .f4_3_rdata(rd0[2]), .f4_4_rdata(rd0[3]),
    .f4_5_rdata(rd0[4]), .f4_6_rdata(rd0[5]), .f4_7_rdata(rd0[6]), .f4_8_rdata(rd0[7]),
    .f4_9_rdata(rd0[8]), .f4_10_rdata(rd0[9]), .f4_11_rdata(rd0[10]), .f4_12_rdata(rd0[11]),
    .f4_13_rdata(rd0[12]), .f4_14_rdata(rd0[13]), .f4_15_rdata(rd0[14]), .f4_16_rdata(rd0[15]),
    .fc_data(data0), .fc_index(idx0), .fc_last(last0), .fc_valid(valid0), .fc_ready(fc_ready));
  f4_ram_reader #(.DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .f4_raddr(raddr1),
    .f4_1_rdata(rd1[0]), .f4_2_rdata(rd1[1]), .f4_3_rdata(rd1[2]), .f4_4_rdata(rd1[3]),
    .f4_5_rdata(rd1[4]), .f4_6_rdata(rd1[5]), .f4_7_rdata(rd1[6]), .f4_8_rdata(rd1[7]),
    .f4_9_rdata(rd1[8]), .f4_10_rdata(rd1[9]), .f4_11_rdata(rd1[10]), .f4_12_rdata(rd1[11]),
    .f4_13_rdata(rd1[12]), .f4_14_rdata(rd1[13]), .f4_15_rdata(rd1[14]), .f4_16_rdata(rd1[15]),
    .fc_data(data1), .fc_index(idx1), .fc_last(last1), .fc_valid(valid1), .fc_ready(fc_ready));
  logic o_busy, o_done, o_last, o_valid;
  logic [6:0]  o_raddr;
  logic [15:0] o_data;
  logic [8:0]  o_idx;
  assign o_busy  = sel ? busy1  : busy0;
  assign o_done  = sel ? done1  : done0;
  assign o_last  = sel ? last1  : last0;
  assign o_valid = sel ? valid1 : valid0;
  assign o_raddr = sel ? raddr1 : raddr0;
  assign o_data  = sel ? data1  : data0;
  assign o_idx   = sel ? idx1   : idx0;
  int checks = 0, errors = 0;
  int beat_idx[$], beat_data[$], last_seen[$], done_cyc[$], exp_idx[$], exp_data[$];
  int first_cyc, last_cyc, busy_low_cyc, hold_err, stall_cnt, raddr_max, post_busy, abort_nonzero;
  bit timed_out;
  task automatic init_ramp();
    for (int a = 0; a < 128; a++) for (int k = 0; k < 16; k++) mem[a][k] = 16'(a * 16 + k + 1);
  endtask
  task automatic init_random();
    for (int a = 0; a < 128; a++) for (int k = 0; k < 16; k++) mem[a][k] = 16'($urandom);
  endtask
  // expected stream: words in address order, channels in order within a word
  task automatic build_model(input int d);
    exp_idx = {}; exp_data = {};
    for (int a = 0; a < d; a++)
      for (int k = 0; k < 16; k++) begin
        exp_idx.push_back(a * 16 + k);
        exp_data.push_back(int'(mem[a][k]));
      end
  endtask
  function automatic int stream_mismatch();
    if (beat_idx.size() != exp_idx.size()) return -1;
    foreach (exp_idx[i]) if (beat_idx[i] != exp_idx[i] || beat_data[i] != exp_data[i]) return i + 1;
    return 0;
  endfunction
  // mode 0: ready=1, 1: stall 5 cycles on index 37, 2: random ready
  task automatic run_pass(input bit s, input int mode, input int st_a, input int st_b, input int abort_beat);
    int n, stall37, end_at, pi, pd;
    bit pend, pl, r, st;
    sel = s;
    beat_idx = {}; beat_data = {}; last_seen = {}; done_cyc = {};
    first_cyc = -1; last_cyc = -1; busy_low_cyc = -1; hold_err = 0; stall_cnt = 0;
    raddr_max = 0; post_busy = 0; abort_nonzero = 0; timed_out = 0;
    pend = 0; stall37 = 0; end_at = -1; pi = 0; pd = 0; pl = 0;
    @(negedge clk);
    n = 0;
    forever begin
      if (pend && !(o_valid && int'(o_data) == pd && int'(o_idx) == pi && o_last == pl)) hold_err++;
      if (int'(o_raddr) > raddr_max) raddr_max = int'(o_raddr);
      if (o_valid && first_cyc < 0) first_cyc = n;
      if (o_valid && o_last) last_cyc = n;
      if (o_done) begin
        done_cyc.push_back(n);
        if (end_at < 0) end_at = n + 30;
      end
      if (done_cyc.size() > 0 && n > done_cyc[0] && !o_busy && busy_low_cyc < 0) busy_low_cyc = n;
      if (done_cyc.size() > 0 && n > done_cyc[0] + 1 && (o_busy || o_valid)) post_busy++;
      r = 1;
      if (mode == 1 && o_valid && o_idx == 9'd37 && stall37 < 5) begin r = 0; stall37++; end
      if (mode == 2) r = 1'($urandom_range(0, 1));
      fc_ready = r;
      if (o_valid && !r) stall_cnt++;
      if (o_valid && r) begin
        beat_idx.push_back(int'(o_idx));
        beat_data.push_back(int'(o_data));
        if (o_last) last_seen.push_back(int'(o_idx));
      end
      pend = o_valid && !r; pd = int'(o_data); pi = int'(o_idx); pl = o_last;
      st = (n == 0 || n == st_a || n == st_b);
      start0 = !s && st;
      start1 = s && st;
      if (abort_beat > 0 && beat_idx.size() == abort_beat) begin
        #1 rst_n = 0;
        #1 if ({busy0, done0, valid0, last0, data0, idx0, raddr0} !== '0) abort_nonzero++;
        start0 = 0; start1 = 0; pend = 0; abort_beat = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        n += 3;
        end_at = n + 40;
      end
      if (end_at >= 0 && n >= end_at) break;
      if (n > 3000) begin timed_out = 1; break; end
      @(negedge clk);
      n++;
    end
    start0 = 0; start1 = 0; fc_ready = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    for (int c = 0; c < 5; c++) begin
      start0 = 1'($urandom); start1 = 1'($urandom); fc_ready = 1'($urandom);
      init_random();
      @(negedge clk);
      checks++;
      if ({busy0, done0, valid0, last0, data0, idx0, raddr0, busy1, done1, valid1, last1, data1, idx1, raddr1} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%0b busy=%0b data=%0h idx=%0d raddr=%0d, expected all 0", valid0, busy0, data0, idx0, raddr0);
      end
    end
    start0 = 0; start1 = 0; fc_ready = 0;
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({busy0, done0, valid0, last0, data0, idx0, raddr0, busy1, done1, valid1, last1, data1, idx1, raddr1} !== '0) begin
        errors++;
        $display("FAIL idle_outputs: got valid=%0b busy=%0b raddr=%0d, expected all 0", valid0, busy0, raddr0);
      end
    end
  endtask
  task automatic test_full_pass();
    int m;
    init_ramp();
    build_model(25);
    run_pass(0, 0, -1, -1, 0);
    m = stream_mismatch();
    checks++;
    if (m != 0) begin errors++; $display("FAIL full_stream: beats=%0d mismatch_at=%0d, expected 400 beats data=index+1", beat_idx.size(), m); end
    checks++;
    if (first_cyc != 3) begin errors++; $display("FAIL first_beat_cycle: got %0d expected 3", first_cyc); end
    checks++;
    if (last_seen.size() != 1 || last_seen[0] != 399 || last_cyc != 450) begin
      errors++; $display("FAIL last_beat: count=%0d cycle=%0d expected one on index 399 at cycle 450", last_seen.size(), last_cyc);
    end
    checks++;
    if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 451) begin
      errors++; $display("FAIL done_cycle: count=%0d timeout=%0b expected single done at 451", done_cyc.size(), timed_out);
    end
    checks++;
    if (busy_low_cyc != 452) begin errors++; $display("FAIL busy_low: got cycle %0d expected 452", busy_low_cyc); end
  endtask
  task automatic test_backpressure();
    int m;
    init_ramp();
    build_model(25);
    run_pass(0, 1, -1, -1, 0);
    m = stream_mismatch();
    checks++;
    if (m != 0) begin errors++; $display("FAIL stall_stream: beats=%0d mismatch_at=%0d, expected 400 in order", beat_idx.size(), m); end
    checks++;
    if (hold_err != 0 || stall_cnt != 5) begin errors++; $display("FAIL stall_hold: hold_err=%0d stalls=%0d expected 0 and 5", hold_err, stall_cnt); end
    checks++;
    if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 456) begin
      errors++; $display("FAIL stall_done: count=%0d expected single done at 456", done_cyc.size());
    end
  endtask
  task automatic test_start_ignored();
    init_random();
    build_model(25);
    run_pass(0, 0, 100, 451, 0);
    checks++;
    if (beat_idx.size() != 400 || done_cyc.size() != 1 || post_busy != 0) begin
      errors++; $display("FAIL start_ignored: beats=%0d dones=%0d post_busy=%0d expected 400 1 0", beat_idx.size(), done_cyc.size(), post_busy);
    end
  endtask
  task automatic test_reset_mid_pass();
    int m;
    init_random();
    run_pass(0, 0, -1, -1, 200);
    checks++;
    if (abort_nonzero != 0 || done_cyc.size() != 0 || beat_idx.size() != 200) begin
      errors++; $display("FAIL mid_reset: nonzero=%0d dones=%0d beats=%0d expected 0 0 200", abort_nonzero, done_cyc.size(), beat_idx.size());
    end
    init_random();
    build_model(25);
    run_pass(0, 2, -1, -1, 0);
    m = stream_mismatch();
    checks++;
    if (m != 0 || hold_err != 0) begin errors++; $display("FAIL rand_ready_stream: mismatch_at=%0d hold_err=%0d expected 0 0", m, hold_err); end
    checks++;
    if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 451 + stall_cnt) begin
      errors++; $display("FAIL rand_ready_done: count=%0d expected done at %0d", done_cyc.size(), 451 + stall_cnt);
    end
  endtask
  task automatic test_depth1();
    int m;
    init_random();
    build_model(1);
    run_pass(1, 0, -1, -1, 0);
    m = stream_mismatch();
    checks++;
    if (m != 0 || last_seen.size() != 1 || last_seen[0] != 15) begin
      errors++; $display("FAIL depth1_stream: beats=%0d mismatch_at=%0d lasts=%0d expected 16 beats, last on 15", beat_idx.size(), m, last_seen.size());
    end
    checks++;
    if (raddr_max != 0) begin errors++; $display("FAIL depth1_raddr: got max %0d expected 0", raddr_max); end
    checks++;
    if (timed_out || done_cyc.size() != 1 || done_cyc[0] != 19) begin
      errors++; $display("FAIL depth1_done: count=%0d expected single done at 19", done_cyc.size());
    end
  endtask
  initial begin
    test_reset();
    test_full_pass();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_pass();
    test_depth1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/f4_ram_reader.md
Name: f4_ram_reader

Overview:
- Read-side sequencer for the F4 feature-map RAM (16 channels x 16 bit per word, 7-bit address, 1-cycle registered read latency).
- On a start pulse it walks RAM addresses 0..DEPTH-1 and captures each 256-bit word.
- It serialises each word channel by channel into a 16-bit valid/ready stream for the F5 fully-connected stage, tagging each beat with its flattened index.

Parameters:
- DEPTH, 25, number of F4 words to read (5x5 map positions); legal range 1..128.
- ADDR_W, 7, RAM address width.
- IDX_W, 9, width of the flattened index; must satisfy 2^IDX_W >= DEPTH*16.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to read the full map; sampled only in IDLE.
- busy  out  1  high while a read pass is in progress.
- done  out  1  one-cycle pulse when the pass completes.
- f4_raddr  out  ADDR_W  RAM read address, registered.
- f4_k_rdata (k=1..16)  in  16 each  RAM read data for channel k; valid one cycle after the address is presented.
- fc_data  out  16  serialised feature value.
- fc_index  out  IDX_W  flattened index, addr*16 + (k-1).
- fc_last  out  1  high on the final beat of the pass (index DEPTH*16-1).
- fc_valid  out  1  stream valid.
- fc_ready  in  1  stream ready from the F5 stage.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, f4_raddr=0, fc_valid=0, fc_last=0, fc_data=0, fc_index=0. The word buffer, address counter and channel counter are all cleared.
- Reset asserted mid-pass aborts the pass immediately. No done pulse is produced. After release the block waits in IDLE for a new start.
- States: IDLE, REQ, CAPT, SEND, DONE. busy = (state != IDLE).
  - IDLE: start=1 -> REQ with addr=0, ch=0.
  - REQ: f4_raddr=addr is presented this cycle -> CAPT.
  - CAPT: the RAM output is now valid. Load all 16 f4_k_rdata into a 256-bit word buffer; channel 1 goes in bits 15:0 -> SEND.
  - SEND: fc_valid=1, fc_data = buffer slice ch, fc_index = addr*16+ch, fc_last = (addr==DEPTH-1 && ch==15). On fc_valid && fc_ready:
    - ch<15: ch++.
    - ch==15 and addr<DEPTH-1: addr++, ch=0 -> REQ.
    - ch==15 and addr==DEPTH-1: -> DONE.
  - DONE: done=1 for exactly one cycle, fc_valid=0 -> IDLE.
- f4_raddr always reflects the address register. It changes only on the transition into REQ or on reset.
- Stream rule: once fc_valid=1, fc_data, fc_index and fc_last hold stable until the beat is accepted. fc_valid never drops without a handshake, except on reset.
- start while busy is ignored. start in the DONE cycle is also ignored; a new pass needs start in IDLE.
- Throughput: 18 cycles per word with fc_ready held at 1, consisting of 1 REQ, 1 CAPT and 16 SEND cycles.
- The block performs no read/write hazard check. The F4 writer must have finished before start is issued.
- Index arithmetic is unsigned and uses no saturation. addr is compared against DEPTH-1 exactly, so no wrap beyond DEPTH occurs.

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> every output is 0. Release, then idle 10 cycles -> outputs stay 0 and no RAM address other than 0 is presented.
- Full pass, fc_ready=1, DEPTH=25: preload RAM word a, channel k with a*16+k, start pulsed at cycle 0.
  - First beat at cycle 3: fc_data=1, index 0.
  - Exactly 400 beats follow, with fc_data = index+1 and indices 0..399 in order.
  - fc_last only on index 399, at cycle 450. done=1 at cycle 451, busy=0 at cycle 452.
- Backpressure: drop fc_ready for 5 cycles while presenting index 37 -> fc_valid stays 1 and fc_data=38, index 37 are held. No beat is lost or duplicated, and the pass ends 5 cycles later than in the unstalled run.
- start ignored: pulse start at cycles 100 and 451 during a pass -> only one pass of 400 beats occurs and only one done pulse.
- Reset mid-pass: assert rst_n=0 at beat 200 -> all outputs go to 0 asynchronously and no done pulse follows. A fresh start then produces a complete 400-beat pass beginning at index 0.
- Boundary DEPTH=1: start -> 16 beats with indices 0..15 and fc_last on index 15. f4_raddr stays 0 throughout, and done fires at cycle 19.
